// File: rtl/i2c_sccb_target.sv
// -----------------------------------------------------------------------------
// i2c_sccb_target
// I2C / SCCB register-file target. Accepts "START, addr+W, sub, data..., STOP"
// writes into an internal 256x8 register file (with a wr_en strobe per byte)
// and "START, addr+W, sub, rSTART, addr+R, data..." reads from it. The bus pins
// are oversampled by clk (which must run at least 20x SCL) through a 2-flop
// synchronizer and a 1-flop edge detector.
//
// Ports
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   scl_i   : bus SCL (asynchronous)
//   sda_i   : bus SDA (asynchronous)
//   sda_oe  : 1 = pull SDA low (open-drain), 0 = release
//   wr_en   : one-clk strobe per accepted write data byte
//   wr_addr : register sub-address of the current wr_en
//   wr_data : data byte of the current wr_en
//   busy    : high from an address-matched START until STOP or mismatch
// -----------------------------------------------------------------------------
module i2c_sccb_target #(
    parameter logic [6:0] DEV_ADDR = 7'h21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ACK_ADDR  = 4'd2,
        SUB       = 4'd3,
        ACK_SUB   = 4'd4,
        WDATA     = 4'd5,
        ACK_WDATA = 4'd6,
        RDATA     = 4'd7,
        ACK_RDATA = 4'd8,
        IGNORE    = 4'd9
    } state_t;

    // synchronizer / edge-detector flops (reset high = idle bus)
    logic r_scl_meta;
    logic r_scl_sync;
    logic r_scl_prev;
    logic r_sda_meta;
    logic r_sda_sync;
    logic r_sda_prev;

    // protocol state
    state_t     r_state;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_tx;
    logic [7:0] r_ptr;
    logic       r_rw;
    logic       r_mack;
    logic       r_sda_oe;
    logic       r_wr_en;
    logic [7:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic       r_busy;

    // register file (deliberately not reset)
    logic [7:0] r_mem [0:255];

    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_rd_data;

    assign w_scl_rise = r_scl_sync & ~r_scl_prev;
    assign w_scl_fall = ~r_scl_sync & r_scl_prev;
    // START/STOP require SCL high on both the current and previous sample so
    // that an SDA change coinciding with an SCL edge is not misread.
    assign w_start    = r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
    assign w_stop     = r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;
    assign w_rd_data  = r_mem[r_ptr];

    assign sda_oe  = r_sda_oe;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;

    // Bring SCL/SDA into the clk domain and keep one previous sample for edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_meta <= scl_i;
            r_scl_sync <= r_scl_meta;
            r_scl_prev <= r_scl_sync;
            r_sda_meta <= sda_i;
            r_sda_sync <= r_sda_meta;
            r_sda_prev <= r_sda_sync;
        end
    end

    // Register-file write port, fed by the registered write strobe.
    always_ff @(posedge clk) begin
        if (r_wr_en) begin
            r_mem[r_wr_addr] <= r_wr_data;
        end
    end

    // Protocol FSM: samples on SCL rise, drives SDA on SCL fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
            r_tx      <= 8'h00;
            r_ptr     <= 8'h00;
            r_rw      <= 1'b0;
            r_mack    <= 1'b1;
            r_sda_oe  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 8'h00;
            r_wr_data <= 8'h00;
            r_busy    <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_stop) begin
                // STOP wins over a simultaneous START
                r_state   <= IDLE;
                r_bit_cnt <= 4'd0;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
            end else if (w_start) begin
                r_state   <= ADDR;
                r_bit_cnt <= 4'd0;
                r_sda_oe  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_sda_oe <= 1'b0;
                    end
                    ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[6:0], r_sda_sync};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                            r_bit_cnt <= 4'd0;
                            if (r_shift[7:1] == DEV_ADDR) begin
                                r_state  <= ACK_ADDR;
                                r_rw     <= r_shift[0];
                                r_sda_oe <= 1'b1;
                                r_busy   <= 1'b1;
                            end else begin
                                r_state  <= IGNORE;
                                r_sda_oe <= 1'b0;
                                r_busy   <= 1'b0;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt;
                        end
                    end
                    ACK_ADDR: begin
                        if (w_scl_fall) begin
                            r_bit_cnt <= 4'd0;
                            if (r_rw) begin
                                // first read bit goes out on the same fall that ends ACK
                                r_state  <= RDATA;
                                r_tx     <= w_rd_data;
                                r_sda_oe <= ~w_rd_data[7];
                            end else begin
                                r_state  <= SUB;
                                r_sda_oe <= 1'b0;
                            end
                        end else begin
                            r_state <= ACK_ADDR;
                        end
                    end
                    SUB: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[6:0], r_sda_sync};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                            r_ptr     <= r_shift;
                            r_bit_cnt <= 4'd0;
                            r_state   <= ACK_SUB;
                            r_sda_oe  <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt;
                        end
                    end
                    ACK_SUB, ACK_WDATA: begin
                        if (w_scl_fall) begin
                            r_state   <= WDATA;
                            r_bit_cnt <= 4'd0;
                            r_sda_oe  <= 1'b0;
                        end else begin
                            r_state <= r_state;
                        end
                    end
                    WDATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[6:0], r_sda_sync};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_ptr;
                            r_wr_data <= r_shift;
                            r_ptr     <= r_ptr + 8'd1;
                            r_bit_cnt <= 4'd0;
                            r_state   <= ACK_WDATA;
                            r_sda_oe  <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt;
                        end
                    end
                    RDATA: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                            // release for the master's ACK/NACK slot
                            r_sda_oe  <= 1'b0;
                            r_bit_cnt <= 4'd0;
                            r_state   <= ACK_RDATA;
                        end else if (w_scl_fall && (r_bit_cnt != 4'd0)) begin
                            r_tx     <= {r_tx[6:0], 1'b0};
                            r_sda_oe <= ~r_tx[6];
                        end else begin
                            r_bit_cnt <= r_bit_cnt;
                        end
                    end
                    ACK_RDATA: begin
                        if (w_scl_rise) begin
                            r_mack <= r_sda_sync;
                            r_ptr  <= r_ptr + 8'd1;
                        end else if (w_scl_fall) begin
                            r_bit_cnt <= 4'd0;
                            if (!r_mack) begin
                                r_state  <= RDATA;
                                r_tx     <= w_rd_data;
                                r_sda_oe <= ~w_rd_data[7];
                            end else begin
                                r_state  <= IGNORE;
                                r_sda_oe <= 1'b0;
                            end
                        end else begin
                            r_mack <= r_mack;
                        end
                    end
                    IGNORE: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_bit_cnt <= 4'd0;
                        r_sda_oe  <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_sccb_target.sv
// -----------------------------------------------------------------------------
// tb_i2c_sccb_target
// Directed bench: a bit-banged I2C master (SCL quarter period = 10 clk) drives
// the target over a wired-AND SDA line; wr_en strobes and sda_oe activity are
// logged by a small monitor and compared against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_i2c_sccb_target;

    localparam int Q = 100;   // quarter SCL period (clk period is 10)

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_oe;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       sda_bus;

    int n_checks = 0;
    int n_pass   = 0;

    // monitor state
    int         wr_cnt = 0;
    int         oe_cnt = 0;
    logic [7:0] log_a [0:15];
    logic [7:0] log_d [0:15];

    assign sda_bus = m_sda & ~sda_oe;

    i2c_sccb_target #(.DEV_ADDR(7'h21)) dut (
        .clk     (clk),
        .rst     (rst),
        .scl_i   (scl),
        .sda_i   (sda_bus),
        .sda_oe  (sda_oe),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // log write strobes and count clocks with SDA pulled low by the target
    always @(negedge clk) begin
        if (wr_en) begin
            log_a[wr_cnt % 16] = wr_addr;
            log_d[wr_cnt % 16] = wr_data;
            wr_cnt = wr_cnt + 1;
        end
        if (sda_oe) oe_cnt = oe_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; #(Q);
        scl   = 1'b1; #(Q);
        m_sda = 1'b0; #(Q);
        scl   = 1'b0; #(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #(Q);
        scl   = 1'b1; #(Q);
        m_sda = 1'b1; #(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; #(Q);
        scl   = 1'b1; #(Q);
        #(Q);
        scl   = 1'b0; #(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; #(Q);
        scl   = 1'b1; #(Q);
        b     = sda_bus; #(Q);
        scl   = 1'b0; #(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack_bit);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack_bit);
    endtask

    initial begin
        logic       ack;
        logic       ack1;
        logic       ack2;
        logic       ack3;
        logic       ack4;
        logic [7:0] rd;
        logic [7:0] byte_v;
        int         base;
        int         oe_base;

        #3;
        // reset values
        check("rst_sda_oe",  {15'd0, sda_oe}, 16'd0);
        check("rst_busy",    {15'd0, busy},   16'd0);
        check("rst_wr_en",   {15'd0, wr_en},  16'd0);
        check("rst_wr_addr", {8'd0, wr_addr}, 16'h0000);
        check("rst_wr_data", {8'd0, wr_data}, 16'h0000);
        #40;
        rst = 1'b0;
        #(Q);

        // reset in the middle of the address ACK
        i2c_start();
        byte_v = 8'h42;
        for (int i = 7; i >= 0; i--) write_bit(byte_v[i]);
        check("mid_oe_before_rst",   {15'd0, sda_oe}, 16'd1);
        check("mid_busy_before_rst", {15'd0, busy},   16'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_oe",    {15'd0, sda_oe}, 16'd0);
        check("mid_rst_busy",  {15'd0, busy},   16'd0);
        check("mid_rst_wr_en", {15'd0, wr_en},  16'd0);
        #30;
        rst = 1'b0;
        #(Q);
        i2c_stop();
        base = wr_cnt;
        i2c_start();
        send_byte(8'h42, ack1);
        send_byte(8'h05, ack2);
        send_byte(8'h3C, ack3);
        i2c_stop();
        #(Q);
        check("post_rst_acks", {13'd0, ack1, ack2, ack3}, 16'd0);
        check("post_rst_wr_cnt", 16'(wr_cnt - base), 16'd1);
        check("post_rst_wr", {log_a[base % 16], log_d[base % 16]}, 16'h053C);

        // single write
        base = wr_cnt;
        i2c_start();
        send_byte(8'h42, ack1);
        send_byte(8'h12, ack2);
        send_byte(8'h80, ack3);
        check("wr_busy_during", {15'd0, busy}, 16'd1);
        i2c_stop();
        #(Q);
        check("wr_acks", {13'd0, ack1, ack2, ack3}, 16'd0);
        check("wr_cnt", 16'(wr_cnt - base), 16'd1);
        check("wr_entry", {log_a[base % 16], log_d[base % 16]}, 16'h1280);
        check("wr_busy_after_stop", {15'd0, busy}, 16'd0);
        check("wr_oe_after_stop", {15'd0, sda_oe}, 16'd0);

        // burst write wrapping the pointer
        base = wr_cnt;
        i2c_start();
        send_byte(8'h42, ack1);
        send_byte(8'hFF, ack2);
        send_byte(8'hAA, ack3);
        send_byte(8'h55, ack4);
        i2c_stop();
        #(Q);
        check("burst_acks", {12'd0, ack1, ack2, ack3, ack4}, 16'd0);
        check("burst_cnt", 16'(wr_cnt - base), 16'd2);
        check("burst_entry0", {log_a[base % 16], log_d[base % 16]}, 16'hFFAA);
        check("burst_entry1", {log_a[(base + 1) % 16], log_d[(base + 1) % 16]}, 16'h0055);

        // address mismatch
        base    = wr_cnt;
        oe_base = oe_cnt;
        i2c_start();
        send_byte(8'h44, ack1);
        check("mm_busy_after_addr", {15'd0, busy}, 16'd0);
        send_byte(8'h12, ack2);
        send_byte(8'h80, ack3);
        i2c_stop();
        #(Q);
        check("mm_nacks", {13'd0, ack1, ack2, ack3}, 16'h0007);
        check("mm_oe_clocks", 16'(oe_cnt - oe_base), 16'd0);
        check("mm_wr_cnt", 16'(wr_cnt - base), 16'd0);
        check("mm_busy_end", {15'd0, busy}, 16'd0);

        // read back via repeated START
        i2c_start();
        send_byte(8'h42, ack1);
        send_byte(8'h0A, ack2);
        send_byte(8'h76, ack3);
        send_byte(8'h73, ack4);
        i2c_stop();
        check("rd_setup_acks", {12'd0, ack1, ack2, ack3, ack4}, 16'd0);
        i2c_start();
        send_byte(8'h42, ack1);
        send_byte(8'h0A, ack2);
        i2c_start();
        send_byte(8'h43, ack3);
        check("rd_addr_acks", {13'd0, ack1, ack2, ack3}, 16'd0);
        recv_byte(rd, 1'b0);
        check("rd_byte0", {8'd0, rd}, 16'h0076);
        recv_byte(rd, 1'b1);
        check("rd_byte1", {8'd0, rd}, 16'h0073);
        #(Q);
        check("rd_oe_after_nack", {15'd0, sda_oe}, 16'd0);
        check("rd_busy_before_stop", {15'd0, busy}, 16'd1);
        i2c_stop();
        #(Q);
        check("rd_busy_after_stop", {15'd0, busy}, 16'd0);

        // START glitch in the middle of a data byte
        base = wr_cnt;
        i2c_start();
        send_byte(8'h42, ack1);
        send_byte(8'h20, ack2);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b0);
        write_bit(1'b1);
        check("gl_wr_cnt_partial", 16'(wr_cnt - base), 16'd0);
        i2c_start();
        check("gl_wr_cnt_after_start", 16'(wr_cnt - base), 16'd0);
        send_byte(8'h42, ack3);
        send_byte(8'h30, ack4);
        send_byte(8'h11, ack);
        i2c_stop();
        #(Q);
        check("gl_acks", {11'd0, ack1, ack2, ack3, ack4, ack}, 16'd0);
        check("gl_wr_cnt", 16'(wr_cnt - base), 16'd1);
        check("gl_entry", {log_a[base % 16], log_d[base % 16]}, 16'h3011);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
